nes_joypad_io: RTL and testbench

//  Bus-side responder for the two NES controller ports at $4016/$4017 on the 6502 memory bus.

---
 rtl/nes_joypad_io_pkg.sv | 28 ++
 rtl/joypad_shift.sv | 32 +++
 rtl/nes_joypad_io.sv | 88 ++++++++
 tb/tb_nes_joypad_io.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/nes_joypad_io_pkg.sv
// rtl/nes_joypad_io_pkg.sv - shared constants, button indices and counter helper for the joypad ports
package nes_joypad_io_pkg;

  localparam int JOY_ADDR_WIDTH = 16;
  localparam int JOY_REG_WIDTH  = 8;

  localparam logic [15:0] PAD1_ADDR     = 16'h4016;
  localparam logic [15:0] PAD2_ADDR     = 16'h4017;
  localparam logic [7:0]  OPEN_BUS_4016 = 8'h40;

  localparam logic [3:0]  COUNT_MAX     = 4'd8;

  typedef enum logic [2:0] {
    BTN_A      = 3'd0,
    BTN_B      = 3'd1,
    BTN_SELECT = 3'd2,
    BTN_START  = 3'd3,
    BTN_UP     = 3'd4,
    BTN_DOWN   = 3'd5,
    BTN_LEFT   = 3'd6,
    BTN_RIGHT  = 3'd7
  } btn_idx_e;

  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c >= COUNT_MAX) ? COUNT_MAX : c + 4'd1;
  endfunction

endpackage

// File: rtl/joypad_shift.sv
// rtl/joypad_shift.sv - one controller's 8-bit button shift register with saturating bit counter
module joypad_shift
  import nes_joypad_io_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] buttons,
  output logic       bit_out,
  output logic [3:0] count
);

  logic [7:0] sr;

  // Ones fill from the top, so reads past the eighth bit return 1 like real pads.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr    <= 8'h00;
      count <= 4'd0;
    end else if (load) begin
      sr    <= buttons;
      count <= 4'd0;
    end else if (shift) begin
      sr    <= {1'b1, sr[7:1]};
      count <= sat_inc(count);
    end
  end

  assign bit_out = sr[BTN_A];

endmodule

// File: rtl/nes_joypad_io.sv
// rtl/nes_joypad_io.sv - $4016/$4017 controller port responder on the 6502 memory bus
module nes_joypad_io
  import nes_joypad_io_pkg::*;
#(
  parameter int                      ADDR_WIDTH = JOY_ADDR_WIDTH,
  parameter int                      REG_WIDTH  = JOY_REG_WIDTH,
  parameter logic [ADDR_WIDTH-1:0]   P1_ADDR    = PAD1_ADDR,
  parameter logic [ADDR_WIDTH-1:0]   P2_ADDR    = PAD2_ADDR,
  parameter logic [REG_WIDTH-1:0]    OPEN_BUS   = OPEN_BUS_4016
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [REG_WIDTH-1:0]  din,
  input  logic                  we,
  input  logic                  re,
  output logic [REG_WIDTH-1:0]  dout,
  output logic                  dout_oe,
  input  logic [7:0]            pad1_buttons,
  input  logic [7:0]            pad2_buttons,
  output logic [3:0]            pad1_count,
  output logic [3:0]            pad2_count
);

  logic strobe;
  logic sel1, sel2;
  logic rd, rd1, rd2;
  logic bit1, bit2;
  logic rd_bit;
  logic unused_din;

  assign sel1 = (addr == P1_ADDR);
  assign sel2 = (addr == P2_ADDR);

  // A write in the same cycle wins; the read is dropped entirely.
  assign rd  = re && !we;
  assign rd1 = rd && sel1;
  assign rd2 = rd && sel2;

  assign unused_din = ^din[REG_WIDTH-1:1];

  joypad_shift u_pad1 (
    .clk     (clk),
    .reset   (reset),
    .load    (strobe),
    .shift   (rd1 && !strobe),
    .buttons (pad1_buttons),
    .bit_out (bit1),
    .count   (pad1_count)
  );

  joypad_shift u_pad2 (
    .clk     (clk),
    .reset   (reset),
    .load    (strobe),
    .shift   (rd2 && !strobe),
    .buttons (pad2_buttons),
    .bit_out (bit2),
    .count   (pad2_count)
  );

  // While strobe is high the register is transparent, so A is read live.
  always_comb begin
    rd_bit = 1'b0;
    if (sel1) begin
      rd_bit = strobe ? pad1_buttons[BTN_A] : bit1;
    end else if (sel2) begin
      rd_bit = strobe ? pad2_buttons[BTN_A] : bit2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      strobe  <= 1'b0;
      dout    <= '0;
      dout_oe <= 1'b0;
    end else begin
      if (we && sel1) begin
        strobe <= din[0];
      end
      dout_oe <= rd1 || rd2;
      if (rd1 || rd2) begin
        dout <= OPEN_BUS | {{(REG_WIDTH-1){1'b0}}, rd_bit};
      end
    end
  end

endmodule

// File: tb/tb_nes_joypad_io.sv
// tb/tb_nes_joypad_io.sv - directed self-checking bench for nes_joypad_io
module tb_nes_joypad_io;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic [7:0]  din;
  logic        we;
  logic        re;
  logic [7:0]  dout;
  logic        dout_oe;
  logic [7:0]  pad1_buttons;
  logic [7:0]  pad2_buttons;
  logic [3:0]  pad1_count;
  logic [3:0]  pad2_count;

  int checks   = 0;
  int failures = 0;

  nes_joypad_io dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .din          (din),
    .we           (we),
    .re           (re),
    .dout         (dout),
    .dout_oe      (dout_oe),
    .pad1_buttons (pad1_buttons),
    .pad2_buttons (pad2_buttons),
    .pad1_count   (pad1_count),
    .pad2_count   (pad2_count)
  );

  always #5 clk = ~clk;

  // Every bus task starts and ends 1 time unit after a rising edge.
  task automatic bus_read(input logic [15:0] a);
    addr = a;
    re   = 1'b1;
    @(posedge clk);
    #1;
    re   = 1'b0;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    we = 1'b0; re = 1'b0; addr = 16'h0000; din = 8'h00;
    pad1_buttons = 8'h00; pad2_buttons = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", dout); end
    checks++; if (dout_oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", dout_oe); end
    checks++; if (pad1_count !== 4'd0) begin failures++; $display("FAIL reset_cnt1 got=%0d exp=0", pad1_count); end
    checks++; if (pad2_count !== 4'd0) begin failures++; $display("FAIL reset_cnt2 got=%0d exp=0", pad2_count); end
  endtask

  task automatic test_serial_read();
    logic [7:0] exp_seq [10] = '{8'h41, 8'h40, 8'h41, 8'h40, 8'h40, 8'h41, 8'h40, 8'h41, 8'h41, 8'h41};
    pad1_buttons = 8'hA5;
    bus_write(16'h4016, 8'h01);
    bus_write(16'h4016, 8'h00);
    for (int i = 0; i < 10; i++) begin
      bus_read(16'h4016);
      checks++; if (dout !== exp_seq[i]) begin failures++; $display("FAIL serial_dout[%0d] got=%h exp=%h", i, dout, exp_seq[i]); end
      checks++; if (dout_oe !== 1'b1) begin failures++; $display("FAIL serial_oe[%0d] got=%b exp=1", i, dout_oe); end
    end
    checks++; if (pad1_count !== 4'd8) begin failures++; $display("FAIL serial_cnt1 got=%0d exp=8", pad1_count); end
    @(posedge clk); #1;
    checks++; if (dout_oe !== 1'b0) begin failures++; $display("FAIL serial_oe_drop got=%b exp=0", dout_oe); end
  endtask

  task automatic test_strobe_held();
    bus_write(16'h4016, 8'h01);
    pad1_buttons = 8'h00;
    bus_read(16'h4016);
    checks++; if (dout !== 8'h40) begin failures++; $display("FAIL held_live0 got=%h exp=40", dout); end
    pad1_buttons = 8'h01;
    bus_read(16'h4016);
    checks++; if (dout !== 8'h41) begin failures++; $display("FAIL held_live1 got=%h exp=41", dout); end
    checks++; if (pad1_count !== 4'd0) begin failures++; $display("FAIL held_cnt1 got=%0d exp=0", pad1_count); end
  endtask

  task automatic test_pad2_independent();
    pad1_buttons = 8'hFF;
    pad2_buttons = 8'h80;
    bus_write(16'h4016, 8'h01);
    bus_write(16'h4016, 8'h00);
    for (int i = 0; i < 8; i++) begin
      bus_read(16'h4017);
      checks++;
      if (dout !== ((i == 7) ? 8'h41 : 8'h40)) begin
        failures++; $display("FAIL pad2_dout[%0d] got=%h exp=%h", i, dout, (i == 7) ? 8'h41 : 8'h40);
      end
    end
    checks++; if (pad2_count !== 4'd8) begin failures++; $display("FAIL pad2_cnt2 got=%0d exp=8", pad2_count); end
    checks++; if (pad1_count !== 4'd0) begin failures++; $display("FAIL pad2_cnt1_untouched got=%0d exp=0", pad1_count); end
    bus_read(16'h4016);
    checks++; if (dout !== 8'h41) begin failures++; $display("FAIL pad2_then_pad1 got=%h exp=41", dout); end
    checks++; if (pad1_count !== 4'd1) begin failures++; $display("FAIL pad2_then_cnt1 got=%0d exp=1", pad1_count); end
  endtask

  task automatic test_collision_and_decode();
    addr = 16'h4016; din = 8'h01; we = 1'b1; re = 1'b1;
    @(posedge clk); #1;
    we = 1'b0; re = 1'b0;
    checks++; if (dout_oe !== 1'b0) begin failures++; $display("FAIL collide_oe got=%b exp=0", dout_oe); end
    pad1_buttons = 8'h01;
    bus_read(16'h4016);
    checks++; if (dout !== 8'h41) begin failures++; $display("FAIL collide_strobe_live got=%h exp=41", dout); end
    checks++; if (pad1_count !== 4'd0) begin failures++; $display("FAIL collide_cnt1 got=%0d exp=0", pad1_count); end
    pad1_buttons = 8'h00;
    bus_read(16'h4016);
    checks++; if (dout !== 8'h40) begin failures++; $display("FAIL collide_live0 got=%h exp=40", dout); end
    bus_read(16'h5000);
    checks++; if (dout_oe !== 1'b0) begin failures++; $display("FAIL other_addr_oe got=%b exp=0", dout_oe); end
    checks++; if (dout !== 8'h40) begin failures++; $display("FAIL other_addr_hold got=%h exp=40", dout); end
    bus_write(16'h4017, 8'h00);
    pad1_buttons = 8'h01;
    bus_read(16'h4016);
    checks++; if (dout !== 8'h41) begin failures++; $display("FAIL pad2_write_ignored got=%h exp=41", dout); end
    checks++; if (pad1_count !== 4'd0) begin failures++; $display("FAIL pad2_write_cnt1 got=%0d exp=0", pad1_count); end
    bus_write(16'h4016, 8'h00);
    bus_read(16'h4016);
    checks++; if (dout !== 8'h41) begin failures++; $display("FAIL relatch_bit0 got=%h exp=41", dout); end
    bus_read(16'h4016);
    checks++; if (dout !== 8'h40) begin failures++; $display("FAIL relatch_bit1 got=%h exp=40", dout); end
    checks++; if (pad1_count !== 4'd2) begin failures++; $display("FAIL relatch_cnt1 got=%0d exp=2", pad1_count); end
  endtask

  task automatic test_reset_mid_sequence();
    logic [7:0] exp_pre [3] = '{8'h41, 8'h40, 8'h41};
    pad1_buttons = 8'hA5;
    bus_write(16'h4016, 8'h01);
    bus_write(16'h4016, 8'h00);
    for (int i = 0; i < 3; i++) begin
      bus_read(16'h4016);
      checks++; if (dout !== exp_pre[i]) begin failures++; $display("FAIL midrst_pre[%0d] got=%h exp=%h", i, dout, exp_pre[i]); end
    end
    addr = 16'h4016; re = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    re = 1'b0; reset = 1'b0;
    checks++; if (dout_oe !== 1'b0) begin failures++; $display("FAIL midrst_oe got=%b exp=0", dout_oe); end
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL midrst_dout got=%h exp=00", dout); end
    checks++; if (pad1_count !== 4'd0) begin failures++; $display("FAIL midrst_cnt1 got=%0d exp=0", pad1_count); end
    for (int i = 0; i < 9; i++) begin
      bus_read(16'h4016);
      checks++;
      if (dout !== ((i == 8) ? 8'h41 : 8'h40)) begin
        failures++; $display("FAIL midrst_post[%0d] got=%h exp=%h", i, dout, (i == 8) ? 8'h41 : 8'h40);
      end
    end
    checks++; if (pad1_count !== 4'd8) begin failures++; $display("FAIL midrst_cnt_sat got=%0d exp=8", pad1_count); end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_serial_read();
    test_strobe_held();
    test_pad2_independent();
    test_collision_and_decode();
    test_reset_mid_sequence();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
